// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
//  state_e       : sequencer states (2-bit encoding)
//  stage_ctrl_t  : per-stage enable/flush bundle driven to the datapath
//  REG_ZERO      : x0 register index, never a true dependency
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_FAULT    = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_flush;
    } stage_ctrl_t;

    // Normal flow: every latch loads, nothing flushed.
    function automatic stage_ctrl_t ctrl_run();
        stage_ctrl_t c;
        c = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
              id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_flush: 1'b0};
        return c;
    endfunction

    // Whole front end frozen while MEM is stuck; WB receives bubbles.
    function automatic stage_ctrl_t ctrl_freeze();
        stage_ctrl_t c;
        c = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0,
              id_ex_flush: 1'b0, ex_mem_en: 1'b0, mem_wb_flush: 1'b1};
        return c;
    endfunction

    // Redirect: keep fetching from the new target, squash the two wrong-path instrs.
    function automatic stage_ctrl_t ctrl_redirect();
        stage_ctrl_t c;
        c = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_en: 1'b1,
              id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_flush: 1'b0};
        return c;
    endfunction

    // Load-use: hold PC and IF/ID, insert one bubble into EX, let the load advance.
    function automatic stage_ctrl_t ctrl_load_use();
        stage_ctrl_t c;
        c = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b1,
              id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_flush: 1'b0};
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
//  clk, rst_n : clock, asynchronous active-low reset (clears to 0)
//  inc        : count this cycle
//  q          : current count, sticks at all-ones
module pipeline_hazard_ctrl_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (inc && !(&q)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use interlock, redirect flush,
// data-memory wait freeze with timeout fault.
//  Inputs : clk, rst_n, ID source regs/uses, EX rd/load/regwrite/redirect,
//           MEM request, dmem_ready
//  Outputs: per-stage enables/flushes (combinational from state + inputs),
//           mem_fault (registered, sticky), stall_cnt / flush_cnt (saturating)
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_MemReadEn,
    input  logic             ex_RegWriteEn,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_flush,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic   [WAIT_W-1:0] wait_q, wait_d;
    logic                fault_d;
    logic                load_use;
    logic                mem_busy;
    stage_ctrl_t         flow_ctrl;
    stage_ctrl_t         ctrl;

    assign load_use = ex_MemReadEn && ex_RegWriteEn && (ex_rd != REG_ZERO)
                   && ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    assign mem_busy = mem_req && !dmem_ready;

    // Decode once memory is not blocking: redirect wins over load-use (ID instr is wrong-path).
    always_comb begin
        flow_ctrl = ctrl_run();
        if (ex_redirect) begin
            flow_ctrl = ctrl_redirect();
        end else if (load_use) begin
            flow_ctrl = ctrl_load_use();
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        fault_d = mem_fault;
        ctrl    = flow_ctrl;
        unique case (state_q)
            S_RUN: begin
                if (mem_busy) begin
                    ctrl    = ctrl_freeze();
                    state_d = S_MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end
            end
            S_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = S_RUN;
                    wait_d  = '0;
                end else begin
                    ctrl = ctrl_freeze();
                    if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            S_FAULT: begin
                ctrl = ctrl_freeze();
            end
            default: begin
                state_d = S_RUN;
                wait_d  = '0;
            end
        endcase
        // Datapath sees free-flowing enables while held in reset.
        if (!rst_n) begin
            ctrl = ctrl_run();
        end
    end

    // State, wait counter and sticky fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RUN;
            wait_q    <= '0;
            mem_fault <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_fault <= fault_d;
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign if_id_en     = ctrl.if_id_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_en     = ctrl.id_ex_en;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_en    = ctrl.ex_mem_en;
    assign mem_wb_flush = ctrl.mem_wb_flush;

    // if_id_flush is raised only by an accepted redirect.
    pipeline_hazard_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!ctrl.pc_en),
        .q     (stall_cnt)
    );

    pipeline_hazard_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctrl.if_id_flush),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run against a behavioural model of the sequencing rules.
module tb_pipeline_hazard_ctrl;

    localparam int T = 4;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_MemReadEn, ex_RegWriteEn, ex_redirect;
    logic       mem_req, dmem_ready;

    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
    logic        mem_fault;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_flush, s_ex_mem_en;
    logic        s_mem_wb_flush, s_mem_fault;
    logic [2:0]  s_stall_cnt, s_flush_cnt;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_MemReadEn(ex_MemReadEn), .ex_RegWriteEn(ex_RegWriteEn),
        .ex_redirect(ex_redirect), .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .mem_wb_flush(mem_wb_flush), .mem_fault(mem_fault),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_MemReadEn(ex_MemReadEn), .ex_RegWriteEn(ex_RegWriteEn),
        .ex_redirect(ex_redirect), .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_en(s_pc_en), .if_id_en(s_if_id_en), .if_id_flush(s_if_id_flush),
        .id_ex_en(s_id_ex_en), .id_ex_flush(s_id_ex_flush), .ex_mem_en(s_ex_mem_en),
        .mem_wb_flush(s_mem_wb_flush), .mem_fault(s_mem_fault),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: mode 0=running, 1=waiting on memory, 2=faulted.
    int m_mode, m_wait, m_stall, m_flush;
    bit m_fault;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}
    logic [6:0]  exp_ctl, obs_ctl;
    logic [31:0] obs_stall, obs_flush;
    logic [2:0]  obs_stall_s, obs_flush_s;
    logic        obs_fault;

    localparam logic [6:0] CTL_RUN    = 7'b1101010;
    localparam logic [6:0] CTL_REDIR  = 7'b1111110;
    localparam logic [6:0] CTL_LU     = 7'b0001110;
    localparam logic [6:0] CTL_FREEZE = 7'b0000001;

    function automatic logic [6:0] model_ctl();
        bit lu, busy;
        lu = ex_MemReadEn && ex_RegWriteEn && (ex_rd != 5'd0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        busy = mem_req && !dmem_ready;
        if (!rst_n) return CTL_RUN;
        if (m_mode == 2) return CTL_FREEZE;
        if (m_mode == 1 && !dmem_ready) return CTL_FREEZE;
        if (m_mode == 0 && busy) return CTL_FREEZE;
        if (ex_redirect) return CTL_REDIR;
        if (lu) return CTL_LU;
        return CTL_RUN;
    endfunction

    function automatic logic [2:0] sat3(input int v);
        return (v > 7) ? 3'd7 : 3'(v);
    endfunction

    task automatic set_idle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = 0;
        ex_MemReadEn = 0; ex_RegWriteEn = 0; ex_redirect = 0; mem_req = 0; dmem_ready = 1;
    endtask

    task automatic model_reset();
        m_mode = 0; m_wait = 0; m_fault = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_idle();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: sample combinational outputs before the edge, then registered state after it.
    task automatic cycle();
        bit busy;
        @(negedge clk);
        #1;
        exp_ctl = model_ctl();
        obs_ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush};
        busy = mem_req && !dmem_ready;
        @(posedge clk);
        #1;
        if (!exp_ctl[6]) m_stall++;
        if (exp_ctl[4]) m_flush++;
        case (m_mode)
            0: if (busy) begin m_mode = 1; m_wait = 1; end
            1: begin
                if (dmem_ready) begin m_mode = 0; m_wait = 0; end
                else if (m_wait == T) begin m_mode = 2; m_fault = 1; end
                else m_wait++;
            end
            default: ;
        endcase
        obs_stall   = stall_cnt;
        obs_flush   = flush_cnt;
        obs_fault   = mem_fault;
        obs_stall_s = s_stall_cnt;
        obs_flush_s = s_flush_cnt;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_idle();
        model_reset();
        #1;
        checks++;
        if ({pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush} !== CTL_RUN) begin
            failures++;
            $display("FAIL reset_ctl: got %b want %b",
                     {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}, CTL_RUN);
        end
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || mem_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got stall=%0d flush=%0d fault=%b want 0 0 0", stall_cnt, flush_cnt, mem_fault);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        do_reset();
        ex_MemReadEn = 1; ex_RegWriteEn = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
        cycle();
        checks++;
        if (obs_ctl !== CTL_LU) begin
            failures++; $display("FAIL load_use_ctl: got %b want %b", obs_ctl, CTL_LU);
        end
        checks++;
        if (obs_stall !== 32'd1) begin
            failures++; $display("FAIL load_use_stall: got %0d want 1", obs_stall);
        end
        // The load has moved on; EX now holds the bubble.
        ex_MemReadEn = 0; ex_RegWriteEn = 0; ex_rd = 0;
        cycle();
        checks++;
        if (obs_ctl !== CTL_RUN || obs_stall !== 32'd1) begin
            failures++; $display("FAIL load_use_release: got %b stall=%0d want %b stall=1", obs_ctl, obs_stall, CTL_RUN);
        end
        // rs2 path interlocks as well.
        ex_MemReadEn = 1; ex_RegWriteEn = 1; ex_rd = 5'd9; id_rs1 = 5'd3; id_rs2 = 5'd9; id_use_rs2 = 1;
        cycle();
        checks++;
        if (obs_ctl !== CTL_LU || obs_stall !== 32'd2) begin
            failures++; $display("FAIL load_use_rs2: got %b stall=%0d want %b stall=2", obs_ctl, obs_stall, CTL_LU);
        end
    endtask

    task automatic test_rd_zero();
        do_reset();
        ex_MemReadEn = 1; ex_RegWriteEn = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1;
        cycle();
        checks++;
        if (obs_ctl !== CTL_RUN || obs_stall !== 32'd0) begin
            failures++; $display("FAIL rd_zero: got %b stall=%0d want %b stall=0", obs_ctl, obs_stall, CTL_RUN);
        end
    endtask

    task automatic test_redirect_load_use();
        do_reset();
        ex_MemReadEn = 1; ex_RegWriteEn = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1; ex_redirect = 1;
        cycle();
        checks++;
        if (obs_ctl !== CTL_REDIR) begin
            failures++; $display("FAIL redir_lu_ctl: got %b want %b", obs_ctl, CTL_REDIR);
        end
        checks++;
        if (obs_flush !== 32'd1 || obs_stall !== 32'd0) begin
            failures++; $display("FAIL redir_lu_cnt: got flush=%0d stall=%0d want 1 0", obs_flush, obs_stall);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (obs_ctl !== CTL_FREEZE) begin
                failures++; $display("FAIL mem_wait_freeze%0d: got %b want %b", i, obs_ctl, CTL_FREEZE);
            end
        end
        dmem_ready = 1;
        cycle();
        checks++;
        if (obs_ctl !== CTL_RUN || obs_stall !== 32'd3) begin
            failures++; $display("FAIL mem_wait_release: got %b stall=%0d want %b stall=3", obs_ctl, obs_stall, CTL_RUN);
        end
        // Back in run: a ready-on-first-cycle request costs nothing.
        cycle();
        checks++;
        if (obs_ctl !== CTL_RUN || obs_stall !== 32'd3 || obs_fault !== 1'b0) begin
            failures++; $display("FAIL mem_ready_first: got %b stall=%0d fault=%b want %b 3 0", obs_ctl, obs_stall, obs_fault, CTL_RUN);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1; dmem_ready = 0;
        for (int i = 1; i <= T + 1; i++) begin
            cycle();
            checks++;
            if (obs_fault !== ((i == T + 1) ? 1'b1 : 1'b0)) begin
                failures++; $display("FAIL timeout_fault_c%0d: got %b want %b", i, obs_fault, (i == T + 1));
            end
        end
        dmem_ready = 1; mem_req = 0; ex_redirect = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (obs_ctl !== CTL_FREEZE || obs_fault !== 1'b1 || obs_flush !== 32'd0) begin
                failures++; $display("FAIL fault_hold%0d: got %b fault=%b flush=%0d want %b 1 0", i, obs_ctl, obs_fault, obs_flush, CTL_FREEZE);
            end
        end
        checks++;
        if (obs_stall !== 32'(T + 4)) begin
            failures++; $display("FAIL fault_stall: got %0d want %0d", obs_stall, T + 4);
        end
        // Asynchronous reset pulse in the middle of a cycle.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_fault !== 1'b0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || pc_en !== 1'b1) begin
            failures++; $display("FAIL fault_reset: got fault=%b stall=%0d flush=%0d pc_en=%b want 0 0 0 1", mem_fault, stall_cnt, flush_cnt, pc_en);
        end
        set_idle();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mem_req = 1; dmem_ready = 0;
        cycle();
        cycle();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush} !== CTL_RUN || stall_cnt !== 32'd0) begin
            failures++; $display("FAIL reset_mid_wait: got pc_en=%b stall=%0d want 1 0", pc_en, stall_cnt);
        end
        set_idle();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        checks++;
        if (obs_ctl !== CTL_RUN || obs_stall !== 32'd0) begin
            failures++; $display("FAIL after_mid_reset: got %b stall=%0d want %b 0", obs_ctl, obs_stall, CTL_RUN);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        mem_req = 1; dmem_ready = 0;
        for (int i = 1; i <= 15; i++) begin
            cycle();
            checks++;
            if (obs_stall_s !== sat3(i)) begin
                failures++; $display("FAIL sat_stall_c%0d: got %0d want %0d", i, obs_stall_s, sat3(i));
            end
        end
        checks++;
        if (obs_stall !== 32'd15 || obs_stall_s !== 3'd7) begin
            failures++; $display("FAIL sat_final: got wide=%0d narrow=%0d want 15 7", obs_stall, obs_stall_s);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            ex_rd         = 5'($urandom_range(0, 3));
            id_use_rs1    = 1'($urandom_range(0, 1));
            id_use_rs2    = 1'($urandom_range(0, 1));
            ex_MemReadEn  = 1'($urandom_range(0, 1));
            ex_RegWriteEn = ($urandom_range(0, 3) != 0);
            ex_redirect   = ($urandom_range(0, 4) == 0);
            mem_req       = 1'($urandom_range(0, 1));
            dmem_ready    = ($urandom_range(0, 3) != 0);
            cycle();
            checks++;
            if (obs_ctl !== exp_ctl) begin
                failures++; $display("FAIL rnd_ctl n=%0d: got %b want %b", n, obs_ctl, exp_ctl);
            end
            checks++;
            if (obs_stall !== 32'(m_stall) || obs_flush !== 32'(m_flush) || obs_fault !== m_fault) begin
                failures++; $display("FAIL rnd_state n=%0d: got stall=%0d flush=%0d fault=%b want %0d %0d %b",
                                     n, obs_stall, obs_flush, obs_fault, m_stall, m_flush, m_fault);
            end
            checks++;
            if (obs_stall_s !== sat3(m_stall) || obs_flush_s !== sat3(m_flush)) begin
                failures++; $display("FAIL rnd_sat n=%0d: got stall=%0d flush=%0d want %0d %0d",
                                     n, obs_stall_s, obs_flush_s, sat3(m_stall), sat3(m_flush));
            end
            if (m_mode == 2 && $urandom_range(0, 3) == 0) do_reset();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        model_reset();
        test_reset();
        test_load_use();
        test_rd_zero();
        test_redirect_load_use();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
